// File: rtl/fetch_ctrl.sv
// Fetch-stage control: turns pipeline and interrupt events into registered PC-source/increment controls.
// Optional FETCH_CTRL_PERF_EN adds a saturating stall_cnt output.
module fetch_ctrl #(
    parameter int         DRAIN_CYCLES = 3,
    parameter logic [3:0] RST_PLACE    = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       instr_is_32,
    input  logic       call_taken,
    input  logic       is_ret,
    input  logic       ret_valid,
    input  logic       exc_valid,
    input  logic [1:0] exc_code,
    input  logic       int_req,
    input  logic [2:0] int_index,
    output logic [3:0] pc_place,
    output logic [1:0] pc_select,
    output logic [2:0] index,
    output logic       enableBuf,
    output logic       flush,
    output logic       int_ack,
    output logic       busy
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_RST_LOAD,
        ST_RUN,
        ST_RET_WAIT,
        ST_INT_DRAIN,
        ST_INT_VECTOR
    } state_t;

    localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0] PLACE_INC   = 4'b0000;
    localparam logic [3:0] PLACE_EXC   = 4'b0001;
    localparam logic [3:0] PLACE_IVT   = 4'b0101;
    localparam logic [3:0] PLACE_RET   = 4'b0110;
    localparam logic [3:0] PLACE_CALL  = 4'b0111;
    localparam logic [1:0] SEL_HOLD    = 2'b00;
    localparam logic [1:0] SEL_PLUS2   = 2'b01;
    localparam logic [1:0] SEL_PLUS4   = 2'b10;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] index_q, index_d;
    logic       pend_q, pend_d;
    logic [1:0] pend_code_q, pend_code_d;
    logic [3:0] pc_place_q, pc_place_d;
    logic [1:0] pc_select_q, pc_select_d;
    logic       enbuf_q, enbuf_d;
    logic       flush_q, flush_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic [1:0] inc_sel;

    assign inc_sel = instr_is_32 ? SEL_PLUS4 : SEL_PLUS2;

    // Outputs are computed from the transition taken at this edge, so they
    // always describe the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        index_d     = index_q;
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        pc_place_d  = PLACE_INC;
        pc_select_d = SEL_HOLD;
        enbuf_d     = 1'b0;
        flush_d     = 1'b0;
        ack_d       = 1'b0;

        // Exceptions outside RUN are parked and replayed once RUN resumes.
        if (state_q != ST_RUN && state_q != ST_RST_LOAD && exc_valid && !pend_q) begin
            pend_d      = 1'b1;
            pend_code_d = exc_code;
        end

        case (state_q)
            ST_RST_LOAD: begin
                state_d     = ST_RUN;
                pc_select_d = inc_sel;
                enbuf_d     = 1'b1;
            end
            ST_RUN: begin
                pc_select_d = inc_sel;
                enbuf_d     = 1'b1;
                if (pend_q) begin
                    pc_place_d  = PLACE_EXC + {2'b00, pend_code_q};
                    flush_d     = 1'b1;
                    pend_d      = exc_valid;
                    pend_code_d = exc_code;
                end else if (exc_valid) begin
                    pc_place_d = PLACE_EXC + {2'b00, exc_code};
                    flush_d    = 1'b1;
                end else if (call_taken) begin
                    pc_place_d = PLACE_CALL;
                    flush_d    = 1'b1;
                end else if (is_ret) begin
                    state_d     = ST_RET_WAIT;
                    pc_select_d = SEL_HOLD;
                    enbuf_d     = 1'b0;
                end else if (int_req) begin
                    state_d     = ST_INT_DRAIN;
                    index_d     = int_index;
                    cnt_d       = DRAIN_LOAD;
                    pc_select_d = SEL_HOLD;
                    enbuf_d     = 1'b0;
                end else if (stall) begin
                    pc_select_d = SEL_HOLD;
                    enbuf_d     = 1'b0;
                end
            end
            ST_RET_WAIT: begin
                if (ret_valid) begin
                    state_d    = ST_RUN;
                    pc_place_d = PLACE_RET;
                    flush_d    = 1'b1;
                    enbuf_d    = 1'b1;
                end
            end
            ST_INT_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_INT_VECTOR;
                    pc_place_d = PLACE_IVT;
                    ack_d      = 1'b1;
                    flush_d    = 1'b1;
                    enbuf_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_INT_VECTOR: begin
                // int_req is not sampled here: the source drops it in response
                // to int_ack, so only a level still high next cycle re-triggers.
                state_d     = ST_RUN;
                pc_select_d = inc_sel;
                enbuf_d     = 1'b1;
            end
            default: begin
                state_d = ST_RST_LOAD;
            end
        endcase

        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RST_LOAD;
            cnt_q       <= 4'd0;
            index_q     <= 3'd0;
            pend_q      <= 1'b0;
            pend_code_q <= 2'd0;
            pc_place_q  <= RST_PLACE;
            pc_select_q <= SEL_HOLD;
            enbuf_q     <= 1'b0;
            flush_q     <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            index_q     <= index_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            pc_place_q  <= pc_place_d;
            pc_select_q <= pc_select_d;
            enbuf_q     <= enbuf_d;
            flush_q     <= flush_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign pc_place  = pc_place_q;
    assign pc_select = pc_select_q;
    assign index     = index_q;
    assign enableBuf = enbuf_q;
    assign flush     = flush_q;
    assign int_ack   = ack_q;
    assign busy      = busy_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if (state_q != ST_RST_LOAD && !enbuf_q && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Control-side counterpart of the fetch stage. It generates pc_place, pc_select, index and enableBuf each cycle from decode/execute/memory events and interrupt requests. Registered outputs. The fetch stage consumes them at the next clk edge.

Parameters:
DRAIN_CYCLES, 3, hold cycles between interrupt acceptance and vector load; legal range 1-15.
RST_PLACE, 4'b1000, pc_place code driven during reset-vector load (selects the fetch reset input).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard stall from decode; hold the PC.
instr_is_32  in  1  current instruction is 32-bit; 0 means 16-bit.
call_taken  in  1  call resolved in execute; load the call target.
is_ret  in  1  decode saw a RET; freeze until the return address arrives.
ret_valid  in  1  return address valid from memory stage.
exc_valid  in  1  exception raised.
exc_code  in  2  exception number 0-3.
int_req  in  1  level interrupt request.
int_index  in  3  interrupt vector index.
pc_place  out  4  fetch PC-source code.
pc_select  out  2  01 = +2, 10 = +4, 00 = hold.
index  out  3  latched interrupt index.
enableBuf  out  1  fetch/decode buffer write enable.
flush  out  1  one-cycle pulse; kill the younger instruction in the buffer.
int_ack  out  1  one-cycle pulse at vector load.
busy  out  1  high in any state other than RUN.

Behaviour:
- All outputs are registered. An event sampled at edge N appears on the outputs after edge N. Fetch acts on it at edge N+1.
- Reset values (rst high at an edge): state=RST_LOAD, pc_place=RST_PLACE, pc_select=00, index=0, enableBuf=0, flush=0, int_ack=0, busy=1, drain counter=0. rst overrides everything, including a reset asserted mid-drain or mid-RET_WAIT.
- States: RST_LOAD, RUN, RET_WAIT, INT_DRAIN, INT_VECTOR.
- RST_LOAD: lasts one cycle after rst deasserts, holding pc_place=RST_PLACE. Then go to RUN.
- RUN: default pc_place=0000, enableBuf=1. pc_select=10 if instr_is_32, else 01. Priority, highest first:
  1. exc_valid: pc_place=0001+exc_code (codes 1-4, addresses 0/2/4/6), flush=1, stay in RUN.
  2. call_taken: pc_place=0111, flush=1.
  3. is_ret: go to RET_WAIT, pc_select=00, enableBuf=0.
  4. int_req: go to INT_DRAIN, latch int_index into index, counter=DRAIN_CYCLES-1, pc_select=00, enableBuf=0.
  5. stall: pc_select=00, enableBuf=0, pc_place=0000.
  6. Otherwise: increment as above.
- RET_WAIT: pc_place=0000, pc_select=00, enableBuf=0. On ret_valid: pc_place=0110, flush=1, enableBuf=1, go to RUN. exc_valid in this state is deferred, not dropped (held pending until RUN). int_req is ignored here.
- INT_DRAIN: hold PC. Decrement the counter each cycle. At counter 0, go to INT_VECTOR. index is frozen; int_index changes are ignored.
- INT_VECTOR: one cycle. pc_place=0101 (IVT+index), int_ack=1, flush=1, enableBuf=1. Return to RUN. int_req must be deasserted by the source on int_ack. If it is still high in the cycle after int_ack, it is treated as a new request.
- The drain counter is 4 bits. DRAIN_CYCLES=1 gives an immediate INT_VECTOR on the next cycle.
- flush and int_ack never last more than one cycle.
- pc_place codes 1000-1111 are used only in RST_LOAD.

Optional Feature:
Macro FETCH_CTRL_PERF_EN.
- Defined: adds output port stall_cnt (32-bit). It counts every cycle with enableBuf=0 outside RST_LOAD, saturating at 0xFFFFFFFF, and clears on rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles, then release. Required: pc_place=1000, enableBuf=0 during rst and for 1 cycle after, then pc_place=0000, pc_select=01, enableBuf=1.
- Increment mix: instr_is_32 pattern 0,1,1,0 in RUN. Required: pc_select 01,10,10,01 one cycle later. stall high for 2 cycles gives pc_select=00 and enableBuf=0 for exactly 2 cycles.
- Call and exception in the same cycle: exc_valid=1, exc_code=2, call_taken=1. Required: pc_place=0011, flush=1 for 1 cycle. call_taken alone next gives pc_place=0111.
- Return: is_ret pulse, then ret_valid 4 cycles later. Required: busy=1 and pc_select=00 for 4 cycles, then pc_place=0110 with flush=1 for 1 cycle, then RUN.
- Interrupt with DRAIN_CYCLES=3: int_req=1, int_index=5. Required: 3 hold cycles, then pc_place=0101, index=5, int_ack=1 for 1 cycle. A changed int_index during the drain is not reflected.
- Reset mid-drain: rst asserted in the second INT_DRAIN cycle. Required: int_ack never pulses, outputs return to reset values, and the RST_LOAD sequence repeats.
